// File: rtl/rgb_led_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_led_sched
//  Description : Fixed-priority scheduler sharing one RGB LED between three
//                requesters. Arbitration happens only at PWM frame
//                boundaries. The winner's 24-bit colour and blink flag are
//                held for the whole frame. Three registered PWM bits drive
//                the RGB0PWM/RGB1PWM/RGB2PWM inputs of SB_RGBA_DRV.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TICK_DIV      clk cycles per PWM step (>= 1)
//    BLINK_FRAMES  frames per blink half-period (>= 1)
//  Ports
//    clk        in   1   system clock, rising edge
//    rst_n      in   1   asynchronous active-low reset
//    req        in   3   request valid per slot (slot 2 highest priority)
//    req_rgb    in  72   slot i colour at [24i+23:24i], R=[23:16] G=[15:8] B=[7:0]
//    req_blink  in   3   slot i requests blinking
//    gnt        out  3   one-hot current owner, 000 when idle
//    pwm_r      out  1   red PWM   (RGB0PWM)
//    pwm_g      out  1   green PWM (RGB1PWM)
//    pwm_b      out  1   blue PWM  (RGB2PWM)
//    frame      out  1   one-cycle pulse on each frame boundary
// ============================================================================
module rgb_led_sched #(
   parameter int TICK_DIV     = 188,
   parameter int BLINK_FRAMES = 250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [71:0] req_rgb,
   input  logic [2:0]  req_blink,
   output logic [2:0]  gnt,
   output logic        pwm_r,
   output logic        pwm_g,
   output logic        pwm_b,
   output logic        frame
);

   // Counter widths; a 1-bit counter is kept even when the range is a
   // single value so the logic stays uniform for TICK_DIV/BLINK_FRAMES = 1.
   localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
   localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_FRAMES - 1);

   // ------------------------------------------------------------------------
   // Timebase: prescaler -> step tick -> 8-bit step counter
   // ------------------------------------------------------------------------
   logic [c_PRESC_W-1:0] r_presc;
   logic [7:0]           r_cnt;
   logic                 w_tick;
   logic                 w_boundary;

   assign w_tick     = (r_presc == c_PRESC_MAX);
   // Last step of a frame: the next tick wraps cnt to 0.
   assign w_boundary = w_tick && (r_cnt == 8'hFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + c_PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 8'h00;
      end else if (w_tick) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Fixed-priority winner selection (2 > 1 > 0), used only at boundaries
   // ------------------------------------------------------------------------
   logic [2:0]  w_win_gnt;
   logic [23:0] w_win_rgb;
   logic        w_win_blink;

   always_comb begin
      w_win_gnt   = 3'b000;
      w_win_rgb   = 24'h000000;
      w_win_blink = 1'b0;
      if (req[2]) begin
         w_win_gnt   = 3'b100;
         w_win_rgb   = req_rgb[71:48];
         w_win_blink = req_blink[2];
      end else if (req[1]) begin
         w_win_gnt   = 3'b010;
         w_win_rgb   = req_rgb[47:24];
         w_win_blink = req_blink[1];
      end else if (req[0]) begin
         w_win_gnt   = 3'b001;
         w_win_rgb   = req_rgb[23:0];
         w_win_blink = req_blink[0];
      end
   end

   // Latched owner state: held for a full frame so mid-frame request or
   // colour changes never disturb the LED until the next boundary.
   logic [2:0]  r_gnt;
   logic [23:0] r_duty;
   logic        r_blink;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt   <= 3'b000;
         r_duty  <= 24'h000000;
         r_blink <= 1'b0;
      end else if (w_boundary) begin
         r_gnt   <= w_win_gnt;
         r_duty  <= w_win_rgb;
         r_blink <= w_win_blink;
      end
   end

   // ------------------------------------------------------------------------
   // Blink timer: free-running frame counter, phase toggles on each wrap.
   // Phase resets to "on" so a blinking owner lights up in its first frame.
   // ------------------------------------------------------------------------
   logic [c_BLINK_W-1:0] r_bcnt;
   logic                 r_phase;
   logic                 w_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt  <= '0;
         r_phase <= 1'b1;
      end else if (w_boundary) begin
         if (r_bcnt == c_BLINK_MAX) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_bcnt <= r_bcnt + c_BLINK_W'(1);
         end
      end
   end

   assign w_en = !(r_blink && !r_phase);

   // ------------------------------------------------------------------------
   // PWM compare, one per channel. Bit 2 = red, 1 = green, 0 = blue, which
   // matches the byte order inside the latched colour word.
   // ------------------------------------------------------------------------
   logic [2:0] w_pwm_nxt;
   logic [2:0] r_pwm;
   logic       r_frame;

   for (genvar gi = 0; gi < 3; gi++) begin : g_pwm
      assign w_pwm_nxt[gi] = w_en && (r_duty[8*gi +: 8] > r_cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm   <= 3'b000;
         r_frame <= 1'b0;
      end else begin
         r_pwm   <= w_pwm_nxt;
         r_frame <= w_boundary;
      end
   end

   assign gnt   = r_gnt;
   assign pwm_r = r_pwm[2];
   assign pwm_g = r_pwm[1];
   assign pwm_b = r_pwm[0];
   assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_led_sched
//  Description : Self-checking bench for rgb_led_sched. Two instances share
//                the stimulus: A (TICK_DIV=1, BLINK_FRAMES=2) carries the
//                hand-computed expectations, B (TICK_DIV=3, BLINK_FRAMES=1)
//                exercises the prescaler. A cycle-count based model predicts
//                every output of both instances on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_led_sched;

   localparam int TD_A = 1;
   localparam int BF_A = 2;
   localparam int TD_B = 3;
   localparam int BF_B = 1;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [2:0]  req       = 3'b111;
   logic [71:0] req_rgb   = {3{24'hFFFFFF}};
   logic [2:0]  req_blink = 3'b000;

   logic [2:0]  gnt_a, gnt_b;
   logic        pr_a, pg_a, pb_a, frame_a;
   logic        pr_b, pg_b, pb_b, frame_b;

   rgb_led_sched #(.TICK_DIV(TD_A), .BLINK_FRAMES(BF_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .req_rgb(req_rgb),
      .req_blink(req_blink), .gnt(gnt_a), .pwm_r(pr_a), .pwm_g(pg_a),
      .pwm_b(pb_a), .frame(frame_a)
   );

   rgb_led_sched #(.TICK_DIV(TD_B), .BLINK_FRAMES(BF_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .req_rgb(req_rgb),
      .req_blink(req_blink), .gnt(gnt_b), .pwm_r(pr_b), .pwm_g(pg_b),
      .pwm_b(pb_b), .frame(frame_b)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit saw1  = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // -------------------------------------------------------------------------
   // Model: everything is derived from n = clock edges since reset release.
   //   step count = n / TICK_DIV, cnt = that mod 256, frame length = 256*TD,
   //   boundaries seen f = n / (256*TD), phase on iff (f / BF) is even.
   // Owner state is sampled from the inputs on the edge that completes a frame.
   // -------------------------------------------------------------------------
   int          m_n   [2] = '{0, 0};
   logic [2:0]  m_gnt [2] = '{3'b0, 3'b0};
   logic [23:0] m_rgb [2] = '{24'h0, 24'h0};
   logic        m_blk [2] = '{1'b0, 1'b0};
   logic [2:0]  m_pwm [2] = '{3'b0, 3'b0};
   logic        m_frm [2] = '{1'b0, 1'b0};

   always @(posedge clk or negedge rst_n) begin
      int td, bf, flen, cnt, fr;
      logic en;
      logic [7:0] c8;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_n[i]   = 0;
            m_gnt[i] = 3'b000;
            m_rgb[i] = 24'h0;
            m_blk[i] = 1'b0;
            m_pwm[i] = 3'b000;
            m_frm[i] = 1'b0;
         end else begin
            td   = (i == 0) ? TD_A : TD_B;
            bf   = (i == 0) ? BF_A : BF_B;
            flen = 256 * td;
            cnt  = (m_n[i] / td) % 256;
            fr   = m_n[i] / flen;
            c8   = 8'(cnt);
            en   = !(m_blk[i] && (((fr / bf) % 2) == 1));
            m_pwm[i] = {en && (m_rgb[i][23:16] > c8),
                        en && (m_rgb[i][15:8]  > c8),
                        en && (m_rgb[i][7:0]   > c8)};
            if (((m_n[i] + 1) % flen) == 0) begin
               m_gnt[i] = 3'b000;
               m_rgb[i] = 24'h0;
               m_blk[i] = 1'b0;
               // ascending scan: the highest requesting slot is written last
               for (int s = 0; s < 3; s++) begin
                  if (req[s]) begin
                     m_gnt[i] = 3'(1 << s);
                     m_rgb[i] = req_rgb[24*s +: 24];
                     m_blk[i] = req_blink[s];
                  end
               end
            end
            m_n[i]   = m_n[i] + 1;
            m_frm[i] = ((m_n[i] % flen) == 0);
         end
      end
   end

   // Cycle-by-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      chk("model_a", {25'd0, gnt_a, pr_a, pg_a, pb_a, frame_a},
                     {25'd0, m_gnt[0], m_pwm[0], m_frm[0]});
      chk("model_b", {25'd0, gnt_b, pr_b, pg_b, pb_b, frame_b},
                     {25'd0, m_gnt[1], m_pwm[1], m_frm[1]});
      if (gnt_a == 3'b010 || gnt_b == 3'b010) saw1 = 1'b1;
   end

   // Wait for the next frame pulse of instance A; cyc = falling edges waited.
   task automatic wait_frame(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (frame_a !== 1'b1 && cyc < 2000);
      if (frame_a !== 1'b1) chk("frame_timeout", {31'd0, frame_a}, 32'd1);
   endtask

   // Called on a frame-pulse edge: counts high cycles over the next frame.
   task automatic count_frame(output int cr, output int cg, output int cb);
      cr = 0; cg = 0; cb = 0;
      repeat (256) begin
         @(negedge clk);
         cr += int'(pr_a);
         cg += int'(pg_a);
         cb += int'(pb_a);
      end
   endtask

   initial begin
      int cyc, cr, cg, cb;
      int c [4];

      // Reset held with every slot requesting full white.
      repeat (5) begin
         @(negedge clk);
         chk("rst_gnt",   {29'd0, gnt_a}, 32'd0);
         chk("rst_pwm",   {29'd0, pr_a, pg_a, pb_a}, 32'd0);
         chk("rst_frame", {31'd0, frame_a}, 32'd0);
      end

      // Single requester, slot0 = 0x800000.
      req       = 3'b001;
      req_rgb   = {24'h000000, 24'h000000, 24'h800000};
      req_blink = 3'b000;
      rst_n     = 1'b1;
      wait_frame(cyc);
      chk("first_frame_latency", cyc, 32'd256);
      chk("gnt_first", {29'd0, gnt_a}, 32'd1);
      count_frame(cr, cg, cb);
      chk("half_duty_r", cr, 32'd128);
      chk("half_duty_g", cg, 32'd0);
      chk("half_duty_b", cb, 32'd0);

      // Slot2 and slot1 arrive at cnt=100 while slot0 owns the LED.
      repeat (100) @(negedge clk);
      req     = 3'b111;
      req_rgb = {24'h0000FF, 24'h00FF00, 24'h800000};
      repeat (155) begin
         @(negedge clk);
         chk("gnt_hold", {29'd0, gnt_a}, 32'd1);
      end
      wait_frame(cyc);
      chk("boundary_after_change", cyc, 32'd1);
      chk("gnt_slot2", {29'd0, gnt_a}, 32'd4);
      count_frame(cr, cg, cb);
      chk("full_b", cb, 32'd255);
      chk("full_b_r", cr, 32'd0);
      chk("full_b_g", cg, 32'd0);

      // Duty extremes on the granted slot.
      req_rgb[71:48] = 24'h00FF00;
      wait_frame(cyc);
      count_frame(cr, cg, cb);
      chk("full_g", cg, 32'd255);
      chk("full_g_rb", cr + cb, 32'd0);
      req_rgb[71:48] = 24'h000000;
      wait_frame(cyc);
      count_frame(cr, cg, cb);
      chk("zero_duty", cr + cg + cb, 32'd0);

      // Blink: slot0 red, two frames on / two frames off.
      req       = 3'b001;
      req_rgb   = {24'h000000, 24'h000000, 24'hFF0000};
      req_blink = 3'b001;
      wait_frame(cyc);
      for (int k = 0; k < 4; k++) count_frame(c[k], cg, cb);
      chk("blink_total", c[0] + c[1] + c[2] + c[3], 32'd510);
      for (int k = 0; k < 4; k++)
         chk("blink_level", {31'd0, (c[k] == 0 || c[k] == 255)}, 32'd1);
      chk("blink_shape", {31'd0, (c[0] != c[2]) && (c[1] != c[3])}, 32'd1);
      repeat (50) @(negedge clk);
      req_blink = 3'b000;
      wait_frame(cyc);
      count_frame(cr, cg, cb);
      chk("blink_dropped", cr, 32'd255);

      // Asynchronous reset pulse at cnt=77, between clock edges.
      repeat (77) @(negedge clk);
      chk("pre_reset_r", {31'd0, pr_a}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_gnt_a",  {29'd0, gnt_a}, 32'd0);
      chk("async_pwm_a",  {29'd0, pr_a, pg_a, pb_a}, 32'd0);
      chk("async_gnt_b",  {29'd0, gnt_b}, 32'd0);
      chk("async_pwm_b",  {29'd0, pr_b, pg_b, pb_b}, 32'd0);
      chk("async_frame",  {30'd0, frame_a, frame_b}, 32'd0);
      #1 rst_n = 1'b1;
      wait_frame(cyc);
      chk("restart_latency", cyc, 32'd256);

      // Extra time for the slower instance to cover several frames.
      repeat (1000) @(negedge clk);
      chk("slot1_never_granted", {31'd0, saw1}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rgb_led_sched.md
# rgb_led_sched

Fixed-priority scheduler that shares the single on-chip RGB LED between three requesters (e.g. host command, fault status, heartbeat). It arbitrates at PWM frame boundaries, latches the winner's 24-bit colour and blink flag, and generates three registered PWM bits that feed the RGB0PWM/RGB1PWM/RGB2PWM inputs of the SB_RGBA_DRV primitive. All timing derives from one system clock through an internal prescaler.

## Interface
- TICK_DIV, 188: clk cycles per PWM step (≥1). At 48 MHz this gives ~997 Hz frames.
- BLINK_FRAMES, 250: frames per blink half-period (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  3  request valid per slot; slot 2 is highest priority, slot 0 lowest.
- req_rgb  in  72  slot i colour at [24i+23:24i]: R=[23:16], G=[15:8], B=[7:0] within the slot.
- req_blink  in  3  slot i requests blinking.
- gnt  out  3  one-hot current owner, or 000 when idle.
- pwm_r, pwm_g, pwm_b  out  1 each  PWM to RGB0PWM/RGB1PWM/RGB2PWM.
- frame  out  1  one-cycle pulse on each frame boundary.

## Operation
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when prescaler = TICK_DIV-1. With TICK_DIV=1, tick is high every cycle.
- Step counter `cnt` (8 bit): increments on tick and wraps 255→0. The frame boundary is tick with cnt=255; `frame` is registered to this event.
- Arbitration happens only at the frame boundary:
  - gnt ← one-hot of the highest set req bit, or 000 if none.
  - Latched duty ← winner's req_rgb slot; latched blink ← winner's req_blink.
  - If there is no winner, duty ← 0 and blink ← 0.
- Stable between boundaries: req, req_rgb and req_blink changes mid-frame are ignored until the next boundary. A granted requester dropping req keeps its colour through the end of the current frame.
- Blink timer:
  - Frame counter runs 0..BLINK_FRAMES-1, advancing on each boundary, free-running regardless of grant.
  - On wrap, `phase` toggles.
  - `en` = !(latched_blink && !phase).
- PWM:
  - pwm_x ← en && (duty_x > cnt), unsigned 8-bit compare, registered.
  - Duty 0 gives constant low. Duty 255 gives high for 255 of 256 steps (low at cnt=255).
- No combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, immediate): all outputs 0; prescaler, cnt, blink counter, gnt and duty all 0; phase = 1 (on).
- First tick occurs TICK_DIV cycles after rst_n deasserts. First frame boundary occurs at tick number 256.
- Arbitration latency: gnt, duty and blink update in the cycle after the boundary tick, coincident with cnt=0 and the `frame` pulse. pwm_x reflects the new duty one cycle later (registered compare).
- Request on the boundary cycle: req sampled in the same cycle as boundary tick is honoured at that boundary.
- Simultaneous requests: strict priority 2>1>0. There is no fairness; lower slots can starve.
- Reset mid-frame: outputs drop to 0 asynchronously. Upon release, the sequence restarts from cnt=0 and phase=on, with no grant until the first boundary.
- Period rules:
  - PWM period = 256·TICK_DIV clk.
  - Blink period = 2·BLINK_FRAMES frames.

## Test plan
- Reset: hold rst_n=0 with req=111 and colour FFFFFF on all slots → gnt=000, all pwm=0, frame=0 throughout.
- Single requester, TICK_DIV=1, slot0=0x800000:
  - gnt=001 after the first frame pulse.
  - pwm_r high exactly 128 of each 256 cycles.
  - pwm_g and pwm_b stay 0.
- Priority and mid-frame change:
  - Slot0 owns the LED; assert slot2 (0x0000FF) and slot1 at cnt=100.
  - gnt stays 001 until the next boundary, then becomes 100; pwm_b then runs 255/256 high.
  - Slot1 is never granted.
- Duty extremes:
  - 0x00FF00 → pwm_g low only at cnt=255 (1 cycle per frame with TICK_DIV=1).
  - 0x000000 while granted → all pwm 0.
- Blink, BLINK_FRAMES=2, slot0 colour FF0000 with blink=1:
  - pwm_r active for 2 frames, then 0 for 2 frames, repeating.
  - Dropping req_blink takes effect at the next boundary.
- Async reset mid-frame: pulse rst_n low for a sub-cycle window at cnt=77 → outputs 0 without a clock edge; after release, first frame pulse arrives 256·TICK_DIV cycles later.
